// File: rtl/rx_simplex_init.sv
// rx_simplex_init: receive-side simplex lane initialisation sequencer.
// Tracks alignment, bonding and verification from decoded ordered-set
// indications, and requests a TX re-init on error build-up or stalled init.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   single_lane       1 = single-lane channel, bonding is skipped
//   rx_valid          decoder presents a block this cycle
//   rx_err            block has a decode/sync-header error
//   rx_sp, rx_i, rx_ver  SP / idle / VER ordered-set indications
//   simplex_aligned   sticky alignment status
//   simplex_bonded    sticky bonding status
//   simplex_verified  sticky verification status
//   simplex_reset     one-cycle re-init request to the TX sequencer
//   rx_ready          high while in READY
module rx_simplex_init #(
  parameter int unsigned ALIGN_CNT  = 64,
  parameter int unsigned BOND_CNT   = 16,
  parameter int unsigned VER_CNT    = 64,
  parameter int unsigned ERR_LIMIT  = 4,
  parameter int unsigned ERR_WINDOW = 256,
  parameter int unsigned WATCHDOG   = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic single_lane,
  input  logic rx_valid,
  input  logic rx_err,
  input  logic rx_sp,
  input  logic rx_i,
  input  logic rx_ver,
  output logic simplex_aligned,
  output logic simplex_bonded,
  output logic simplex_verified,
  output logic simplex_reset,
  output logic rx_ready
);

  localparam int unsigned AW = $clog2(ALIGN_CNT + 1);
  localparam int unsigned BW = $clog2(BOND_CNT + 1);
  localparam int unsigned VW = $clog2(VER_CNT + 1);
  localparam int unsigned EW = $clog2(ERR_LIMIT + 1);
  localparam int unsigned GW = $clog2(ERR_WINDOW + 1);
  localparam int unsigned WW = $clog2(WATCHDOG + 1);

  localparam logic [2:0] ST_RESET   = 3'd0;
  localparam logic [2:0] ST_ALIGN   = 3'd1;
  localparam logic [2:0] ST_BONDING = 3'd2;
  localparam logic [2:0] ST_VERIFY  = 3'd3;
  localparam logic [2:0] ST_READY   = 3'd4;

  logic [2:0]    state, state_d;
  logic [AW-1:0] align_cnt, align_cnt_d;
  logic [BW-1:0] bond_cnt, bond_cnt_d;
  logic [VW-1:0] ver_cnt, ver_cnt_d;
  logic [EW-1:0] err_cnt, err_cnt_d;
  logic [GW-1:0] good_run, good_run_d;
  logic [WW-1:0] wd_cnt, wd_cnt_d;
  logic          aligned_d, bonded_d, verified_d, reset_d, ready_d;

  logic good_blk, bad_blk, acc_active, wd_active, err_hit, wd_hit;
  logic sp_unused;

  // SP blocks are plain good blocks for alignment purposes; no extra meaning.
  assign sp_unused  = rx_sp;

  assign good_blk   = rx_valid & ~rx_err;
  assign bad_blk    = rx_valid & rx_err;
  assign acc_active = (state == ST_BONDING) | (state == ST_VERIFY) | (state == ST_READY);
  assign wd_active  = (state == ST_BONDING) | (state == ST_VERIFY);
  assign err_hit    = acc_active & bad_blk & (err_cnt == EW'(ERR_LIMIT - 1));
  assign wd_hit     = wd_active & (wd_cnt == WW'(WATCHDOG - 1));

  // Next-state, counter and flag computation.
  always_comb begin
    state_d     = state;
    align_cnt_d = align_cnt;
    bond_cnt_d  = bond_cnt;
    ver_cnt_d   = ver_cnt;
    err_cnt_d   = err_cnt;
    good_run_d  = good_run;
    wd_cnt_d    = wd_cnt;
    aligned_d   = simplex_aligned;
    bonded_d    = simplex_bonded;
    verified_d  = simplex_verified;
    reset_d     = 1'b0;
    ready_d     = rx_ready;

    // Error accumulator; a full window of clean blocks forgives past errors.
    if (acc_active) begin
      if (bad_blk) begin
        if (err_cnt != EW'(ERR_LIMIT)) err_cnt_d = err_cnt + EW'(1);
        good_run_d = '0;
      end else if (good_blk) begin
        if (good_run == GW'(ERR_WINDOW - 1)) begin
          good_run_d = '0;
          err_cnt_d  = '0;
        end else begin
          good_run_d = good_run + GW'(1);
        end
      end
    end

    if (wd_active && (wd_cnt != WW'(WATCHDOG))) wd_cnt_d = wd_cnt + WW'(1);

    if (err_hit || wd_hit) begin
      // Forced re-init overrides any stage completion this cycle.
      state_d     = ST_RESET;
      align_cnt_d = '0;
      bond_cnt_d  = '0;
      ver_cnt_d   = '0;
      err_cnt_d   = '0;
      good_run_d  = '0;
      wd_cnt_d    = '0;
      aligned_d   = 1'b0;
      bonded_d    = 1'b0;
      verified_d  = 1'b0;
      ready_d     = 1'b0;
      reset_d     = 1'b1;
    end else begin
      case (state)
        ST_RESET: state_d = ST_ALIGN;

        ST_ALIGN: begin
          if (bad_blk) begin
            align_cnt_d = '0;
          end else if (good_blk) begin
            if (align_cnt == AW'(ALIGN_CNT - 1)) begin
              align_cnt_d = AW'(ALIGN_CNT);
              aligned_d   = 1'b1;
              wd_cnt_d    = '0;
              if (single_lane) begin
                bonded_d = 1'b1;
                state_d  = ST_VERIFY;
              end else begin
                state_d  = ST_BONDING;
              end
            end else if (align_cnt != AW'(ALIGN_CNT)) begin
              align_cnt_d = align_cnt + AW'(1);
            end
          end
        end

        ST_BONDING: begin
          if (rx_valid) begin
            if (rx_i && !rx_err) begin
              if (bond_cnt == BW'(BOND_CNT - 1)) begin
                bond_cnt_d = BW'(BOND_CNT);
                bonded_d   = 1'b1;
                wd_cnt_d   = '0;
                state_d    = ST_VERIFY;
              end else if (bond_cnt != BW'(BOND_CNT)) begin
                bond_cnt_d = bond_cnt + BW'(1);
              end
            end else begin
              bond_cnt_d = '0;
            end
          end
        end

        ST_VERIFY: begin
          // VER advances, clean idle holds, anything else restarts the run.
          if (rx_valid) begin
            if (rx_err) begin
              ver_cnt_d = '0;
            end else if (rx_ver) begin
              if (ver_cnt == VW'(VER_CNT - 1)) begin
                ver_cnt_d  = VW'(VER_CNT);
                verified_d = 1'b1;
                ready_d    = 1'b1;
                wd_cnt_d   = '0;
                state_d    = ST_READY;
              end else if (ver_cnt != VW'(VER_CNT)) begin
                ver_cnt_d = ver_cnt + VW'(1);
              end
            end else if (!rx_i) begin
              ver_cnt_d = '0;
            end
          end
        end

        ST_READY: state_d = ST_READY;

        default: state_d = ST_RESET;
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_RESET;
      align_cnt        <= '0;
      bond_cnt         <= '0;
      ver_cnt          <= '0;
      err_cnt          <= '0;
      good_run         <= '0;
      wd_cnt           <= '0;
      simplex_aligned  <= 1'b0;
      simplex_bonded   <= 1'b0;
      simplex_verified <= 1'b0;
      simplex_reset    <= 1'b0;
      rx_ready         <= 1'b0;
    end else begin
      state            <= state_d;
      align_cnt        <= align_cnt_d;
      bond_cnt         <= bond_cnt_d;
      ver_cnt          <= ver_cnt_d;
      err_cnt          <= err_cnt_d;
      good_run         <= good_run_d;
      wd_cnt           <= wd_cnt_d;
      simplex_aligned  <= aligned_d;
      simplex_bonded   <= bonded_d;
      simplex_verified <= verified_d;
      simplex_reset    <= reset_d;
      rx_ready         <= ready_d;
    end
  end

endmodule

// File: tb/tb_rx_simplex_init.sv
// Bench for rx_simplex_init: directed scenarios followed by random blocks,
// every cycle compared against a behavioural model of the init sequence.
module tb_rx_simplex_init;

  localparam int unsigned P_ALIGN = 4;
  localparam int unsigned P_BOND  = 2;
  localparam int unsigned P_VER   = 3;
  localparam int unsigned P_ELIM  = 2;
  localparam int unsigned P_EWIN  = 8;
  localparam int unsigned P_WD    = 20;

  localparam int PH_IDLE = 0, PH_ALIGN = 1, PH_BOND = 2, PH_VER = 3, PH_READY = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic single_lane = 1'b0;
  logic rx_valid = 1'b0, rx_err = 1'b0, rx_sp = 1'b0, rx_i = 1'b0, rx_ver = 1'b0;
  logic simplex_aligned, simplex_bonded, simplex_verified, simplex_reset, rx_ready;

  int n_cmp = 0;
  int n_bad = 0;
  string ctx = "init";
  bit cur_sl = 1'b0;

  // Behavioural model: phase plus run lengths of the relevant block kinds.
  int m_phase, m_align, m_bond, m_ver, m_errs, m_clean, m_wd;
  bit m_al, m_bo, m_ve, m_rst, m_rdy;

  rx_simplex_init #(
    .ALIGN_CNT(P_ALIGN), .BOND_CNT(P_BOND), .VER_CNT(P_VER),
    .ERR_LIMIT(P_ELIM), .ERR_WINDOW(P_EWIN), .WATCHDOG(P_WD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .single_lane(single_lane),
    .rx_valid(rx_valid), .rx_err(rx_err), .rx_sp(rx_sp), .rx_i(rx_i), .rx_ver(rx_ver),
    .simplex_aligned(simplex_aligned), .simplex_bonded(simplex_bonded),
    .simplex_verified(simplex_verified), .simplex_reset(simplex_reset),
    .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    m_phase = PH_IDLE; m_align = 0; m_bond = 0; m_ver = 0;
    m_errs = 0; m_clean = 0; m_wd = 0;
    m_al = 0; m_bo = 0; m_ve = 0; m_rst = 0; m_rdy = 0;
  endfunction

  function automatic void enter(input int p);
    m_phase = p; m_wd = 0; m_bond = 0; m_ver = 0;
  endfunction

  function automatic void model_step(input bit sl, input bit v, input bit e,
                                     input bit ii, input bit ver);
    bit good = v && !e;
    bit bad  = v && e;
    bit kill = 0;
    m_rst = 0;
    if (m_phase >= PH_BOND) begin
      if (bad) begin
        m_errs++; m_clean = 0;
        if (m_errs >= P_ELIM) kill = 1;
      end else if (good) begin
        m_clean++;
        if (m_clean >= P_EWIN) begin m_clean = 0; m_errs = 0; end
      end
    end
    if (m_phase == PH_BOND || m_phase == PH_VER) begin
      m_wd++;
      if (m_wd >= P_WD) kill = 1;
    end
    if (kill) begin
      model_clear();
      m_rst = 1;
      return;
    end
    case (m_phase)
      PH_IDLE: m_phase = PH_ALIGN;
      PH_ALIGN: begin
        if (bad) m_align = 0;
        else if (good) begin
          m_align++;
          if (m_align == P_ALIGN) begin
            m_al = 1; m_align = 0;
            if (sl) begin m_bo = 1; enter(PH_VER); end
            else enter(PH_BOND);
          end
        end
      end
      PH_BOND: if (v) begin
        if (ii && !e) begin
          m_bond++;
          if (m_bond == P_BOND) begin m_bo = 1; enter(PH_VER); end
        end else m_bond = 0;
      end
      PH_VER: if (v) begin
        if (e) m_ver = 0;
        else if (ver) begin
          m_ver++;
          if (m_ver == P_VER) begin m_ve = 1; m_rdy = 1; enter(PH_READY); end
        end else if (!ii) m_ver = 0;
      end
      default: ;
    endcase
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s/%s observed=%0b expected=%0b", ctx, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("aligned",  simplex_aligned,  m_al);
    check("bonded",   simplex_bonded,   m_bo);
    check("verified", simplex_verified, m_ve);
    check("sreset",   simplex_reset,    m_rst);
    check("ready",    rx_ready,         m_rdy);
  endtask

  task automatic step(input bit sl, input bit v, input bit e,
                      input bit sp, input bit ii, input bit ver);
    single_lane = sl; rx_valid = v; rx_err = e; rx_sp = sp; rx_i = ii; rx_ver = ver;
    model_step(sl, v, e, ii, ver);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle(input int n);   for (int k = 0; k < n; k++) step(cur_sl, 0, 0, 0, 0, 0); endtask
  task automatic sp_blk(input int n); for (int k = 0; k < n; k++) step(cur_sl, 1, 0, 1, 0, 0); endtask
  task automatic i_blk(input int n);  for (int k = 0; k < n; k++) step(cur_sl, 1, 0, 0, 1, 0); endtask
  task automatic ver_blk(input int n); for (int k = 0; k < n; k++) step(cur_sl, 1, 0, 0, 0, 1); endtask
  task automatic err_blk();           step(cur_sl, 1, 1, 1, 0, 0); endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    ctx = "reset";
    do_reset();

    // 1: multi-lane full sequence
    ctx = "t1"; cur_sl = 0;
    idle(1);
    sp_blk(3);
    check("t1_not_aligned", simplex_aligned, 1'b0);
    sp_blk(1);
    check("t1_aligned", simplex_aligned, 1'b1);
    check("t1_not_bonded", simplex_bonded, 1'b0);
    i_blk(2);
    check("t1_bonded", simplex_bonded, 1'b1);
    ver_blk(2);
    check("t1_not_verified", simplex_verified, 1'b0);
    ver_blk(1);
    check("t1_verified", simplex_verified, 1'b1);
    check("t1_ready", rx_ready, 1'b1);

    // 2: single lane skips bonding
    ctx = "t2"; do_reset(); cur_sl = 1;
    idle(1);
    sp_blk(4);
    check("t2_aligned", simplex_aligned, 1'b1);
    check("t2_bonded", simplex_bonded, 1'b1);
    ver_blk(3);
    check("t2_verified", simplex_verified, 1'b1);

    // 3: alignment run broken by an error
    ctx = "t3"; do_reset(); cur_sl = 0;
    idle(1);
    sp_blk(3); err_blk(); sp_blk(3);
    check("t3_not_aligned", simplex_aligned, 1'b0);
    sp_blk(1);
    check("t3_aligned", simplex_aligned, 1'b1);
    check("t3_no_sreset", simplex_reset, 1'b0);

    // 4: error limit in READY forces re-init
    ctx = "t4"; do_reset(); cur_sl = 1;
    idle(1); sp_blk(4); ver_blk(3);
    check("t4_ready", rx_ready, 1'b1);
    err_blk(); ver_blk(3); err_blk();
    check("t4_sreset", simplex_reset, 1'b1);
    check("t4_flags_clear", simplex_aligned, 1'b0);
    check("t4_ready_clear", rx_ready, 1'b0);
    idle(1);
    check("t4_pulse_end", simplex_reset, 1'b0);
    sp_blk(4);
    check("t4_realigned", simplex_aligned, 1'b1);

    // 5: error window clears accumulator
    ctx = "t5";
    ver_blk(3);
    err_blk(); ver_blk(8); err_blk();
    check("t5_no_sreset", simplex_reset, 1'b0);
    check("t5_still_ready", rx_ready, 1'b1);

    // 6a: watchdog in BONDING
    ctx = "t6"; do_reset(); cur_sl = 0;
    idle(1); sp_blk(4);
    sp_blk(19);
    check("t6_no_sreset_yet", simplex_reset, 1'b0);
    sp_blk(1);
    check("t6_wd_sreset", simplex_reset, 1'b1);
    check("t6_aligned_clear", simplex_aligned, 1'b0);
    idle(1);

    // 6b: async reset mid-VERIFY
    ctx = "t6b"; do_reset(); cur_sl = 1;
    idle(1); sp_blk(4); ver_blk(1);
    check("t6b_bonded", simplex_bonded, 1'b1);
    do_reset();

    // Random blocks against the model
    ctx = "rand";
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)),
             1'($urandom_range(0, 9) < 8),
             1'($urandom_range(0, 24) == 0),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
